// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the external-memory arbiter state type.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ERR,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// Round-robin request picker: search starts one past the last granted index.
module mpsoc_rr_arbiter #(
  parameter int NODES = 4,
  parameter int IW    = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NODES-1:0] i_req,
  input  logic             i_en,
  output logic [NODES-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] r_last;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    for (int k = 1; k <= NODES; k++) begin
      if (!w_found && i_req[(int'(r_last) + k) % NODES]) begin
        w_found = 1'b1;
        o_idx   = IW'((int'(r_last) + k) % NODES);
      end
    end
    o_gnt = w_found ? (NODES'(1) << o_idx) : '0;
  end

  // Reset pointer to the top index so node 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= IW'(NODES - 1);
    end else if (i_en) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_ext_arbiter.sv
// Serialises NODES tile AHB3-Lite external ports onto one memory slave, round-robin.
// Optional MPSOC_AHB3_EXT_ARB_LOCK_EN keeps the grant on the owner across locked sequences.
module mpsoc_ahb3_ext_arbiter
  import mpsoc_ahb3_pkg::*;
#(
  parameter int PLEN  = 32,
  parameter int XLEN  = 32,
  parameter int NODES = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [NODES-1:0]           ahb3_ext_hsel_i,
  input  logic [NODES-1:0][PLEN-1:0] ahb3_ext_haddr_i,
  input  logic [NODES-1:0][XLEN-1:0] ahb3_ext_hwdata_i,
  input  logic [NODES-1:0]           ahb3_ext_hwrite_i,
  input  logic [NODES-1:0][2:0]      ahb3_ext_hsize_i,
  input  logic [NODES-1:0][2:0]      ahb3_ext_hburst_i,
  input  logic [NODES-1:0][3:0]      ahb3_ext_hprot_i,
  input  logic [NODES-1:0][1:0]      ahb3_ext_htrans_i,
  input  logic [NODES-1:0]           ahb3_ext_hmastlock_i,
  output logic [NODES-1:0][XLEN-1:0] ahb3_ext_hrdata_o,
  output logic [NODES-1:0]           ahb3_ext_hready_o,
  output logic [NODES-1:0]           ahb3_ext_hresp_o,

  output logic                       ahb3_mem_hsel,
  output logic [PLEN-1:0]            ahb3_mem_haddr,
  output logic [XLEN-1:0]            ahb3_mem_hwdata,
  output logic                       ahb3_mem_hwrite,
  output logic [2:0]                 ahb3_mem_hsize,
  output logic [2:0]                 ahb3_mem_hburst,
  output logic [3:0]                 ahb3_mem_hprot,
  output logic [1:0]                 ahb3_mem_htrans,
  output logic                       ahb3_mem_hmastlock,
  input  logic [XLEN-1:0]            ahb3_mem_hrdata,
  input  logic                       ahb3_mem_hready,
  input  logic                       ahb3_mem_hresp
);

  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;

  arb_state_t                 r_state;
  logic [IW-1:0]              r_owner;
  logic                       r_hresp;
  logic [NODES-1:0]           r_pend;
  logic [NODES-1:0][PLEN-1:0] r_haddr;
  logic [NODES-1:0]           r_hwrite;
  logic [NODES-1:0][2:0]      r_hsize;
  logic [NODES-1:0][3:0]      r_hprot;
  logic [NODES-1:0][XLEN-1:0] r_hrdata;

  logic [NODES-1:0]           w_cap;
  logic [NODES-1:0]           w_req;
  logic [NODES-1:0]           w_gnt;
  logic [NODES-1:0]           w_owner_oh;
  logic [IW-1:0]              w_gnt_idx;
  logic                       w_gnt_en;
  logic                       w_mlock;
  logic                       w_unused;

  assign w_owner_oh = NODES'(1) << r_owner;

  assign ahb3_ext_hready_o = ~r_pend | ((r_state == RESP) ? w_owner_oh : '0);
  assign ahb3_ext_hresp_o  = (((r_state == ERR) || (r_state == RESP)) && r_hresp) ? w_owner_oh : '0;
  assign ahb3_ext_hrdata_o = r_hrdata;

  // SEQ and NONSEQ both have htrans[1] set, so both start a fresh capture.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      w_cap[i] = ahb3_ext_hsel_i[i] & ahb3_ext_htrans_i[i][1] & ahb3_ext_hready_o[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NODES; i++) begin
      if (w_cap[i]) begin
        r_haddr[i]  <= ahb3_ext_haddr_i[i];
        r_hwrite[i] <= ahb3_ext_hwrite_i[i];
        r_hsize[i]  <= ahb3_ext_hsize_i[i];
        r_hprot[i]  <= ahb3_ext_hprot_i[i];
      end
    end
  end

  // A capture in the owner's RESP cycle outranks the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_cap | (r_pend & ~((r_state == RESP) ? w_owner_oh : '0));
    end
  end

`ifdef MPSOC_AHB3_EXT_ARB_LOCK_EN
  logic [NODES-1:0] r_hmastlock;
  logic             r_lock;
  logic             w_lock_clr;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NODES; i++) begin
      if (w_cap[i]) begin
        r_hmastlock[i] <= ahb3_ext_hmastlock_i[i];
      end
    end
  end

  assign w_lock_clr = (w_cap[r_owner] && !ahb3_ext_hmastlock_i[r_owner]) ||
                      ((ahb3_ext_htrans_i[r_owner] == HTRANS_IDLE) && ahb3_ext_hready_o[r_owner]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock <= 1'b0;
    end else if ((r_state == ADDR) && r_hmastlock[r_owner]) begin
      r_lock <= 1'b1;
    end else if (w_lock_clr) begin
      r_lock <= 1'b0;
    end
  end

  assign w_req    = (r_pend | w_cap) & (r_lock ? w_owner_oh : '1);
  assign w_mlock  = r_hmastlock[r_owner];
  assign w_unused = ^{ahb3_ext_hburst_i, w_gnt};
`else
  assign w_req    = r_pend | w_cap;
  assign w_mlock  = 1'b0;
  assign w_unused = ^{ahb3_ext_hburst_i, w_gnt, ahb3_ext_hmastlock_i, ahb3_ext_htrans_i};
`endif

  assign w_gnt_en = (r_state == IDLE) && (|w_req);

  mpsoc_rr_arbiter #(
    .NODES (NODES),
    .IW    (IW)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_en  (w_gnt_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_hresp <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_en) begin
          r_owner <= w_gnt_idx;
          r_state <= ADDR;
        end
        ADDR: if (ahb3_mem_hready) r_state <= DATA;
        DATA: if (ahb3_mem_hready) begin
          r_hresp <= ahb3_mem_hresp;
          r_state <= ahb3_mem_hresp ? ERR : RESP;
        end
        ERR:     r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hrdata <= '0;
    end else if ((r_state == DATA) && ahb3_mem_hready) begin
      r_hrdata[r_owner] <= ahb3_mem_hrdata;
    end
  end

  always_comb begin
    ahb3_mem_hsel      = 1'b0;
    ahb3_mem_haddr     = '0;
    ahb3_mem_hwdata    = '0;
    ahb3_mem_hwrite    = 1'b0;
    ahb3_mem_hsize     = 3'b000;
    ahb3_mem_hburst    = HBURST_SINGLE;
    ahb3_mem_hprot     = 4'b0000;
    ahb3_mem_htrans    = HTRANS_IDLE;
    ahb3_mem_hmastlock = 1'b0;
    if (r_state == ADDR) begin
      ahb3_mem_hsel      = 1'b1;
      ahb3_mem_haddr     = r_haddr[r_owner];
      ahb3_mem_hwrite    = r_hwrite[r_owner];
      ahb3_mem_hsize     = r_hsize[r_owner];
      ahb3_mem_hprot     = r_hprot[r_owner];
      ahb3_mem_htrans    = HTRANS_NONSEQ;
      ahb3_mem_hmastlock = w_mlock;
    end
    if (r_state == DATA) begin
      ahb3_mem_hwdata = ahb3_ext_hwdata_i[r_owner];
    end
  end

endmodule

// File: tb/tb_mpsoc_ahb3_ext_arbiter.sv
// Scoreboard bench for mpsoc_ahb3_ext_arbiter: directed transfers, slave model, decoupled monitor.
module tb_mpsoc_ahb3_ext_arbiter;
  import mpsoc_ahb3_pkg::*;

  localparam int PLEN  = 32;
  localparam int XLEN  = 32;
  localparam int NODES = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NODES-1:0]           hsel;
  logic [NODES-1:0][PLEN-1:0] haddr;
  logic [NODES-1:0][XLEN-1:0] hwdata;
  logic [NODES-1:0]           hwrite;
  logic [NODES-1:0][2:0]      hsize;
  logic [NODES-1:0][2:0]      hburst;
  logic [NODES-1:0][3:0]      hprot;
  logic [NODES-1:0][1:0]      htrans;
  logic [NODES-1:0]           hmastlock;
  logic [NODES-1:0][XLEN-1:0] hrdata_o;
  logic [NODES-1:0]           hready_o;
  logic [NODES-1:0]           hresp_o;
  logic            m_hsel;
  logic [PLEN-1:0] m_haddr;
  logic [XLEN-1:0] m_hwdata;
  logic            m_hwrite;
  logic [2:0]      m_hsize;
  logic [2:0]      m_hburst;
  logic [3:0]      m_hprot;
  logic [1:0]      m_htrans;
  logic            m_hmastlock;
  logic [XLEN-1:0] m_hrdata;
  logic            m_hready;
  logic            m_hresp;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } slv_t;
  typedef struct { int node; int stall; logic [31:0] rdata; int nresp; } cmp_t;
  slv_t slv_q[$];
  cmp_t cmp_q[$];

  int total = 0;
  int bad   = 0;
  int          sl_wait  = 0;
  logic        sl_err   = 1'b0;
  logic [31:0] sl_rdata = 32'h0;

  mpsoc_ahb3_ext_arbiter #(.PLEN(PLEN), .XLEN(XLEN), .NODES(NODES)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ahb3_ext_hsel_i      (hsel),
    .ahb3_ext_haddr_i     (haddr),
    .ahb3_ext_hwdata_i    (hwdata),
    .ahb3_ext_hwrite_i    (hwrite),
    .ahb3_ext_hsize_i     (hsize),
    .ahb3_ext_hburst_i    (hburst),
    .ahb3_ext_hprot_i     (hprot),
    .ahb3_ext_htrans_i    (htrans),
    .ahb3_ext_hmastlock_i (hmastlock),
    .ahb3_ext_hrdata_o    (hrdata_o),
    .ahb3_ext_hready_o    (hready_o),
    .ahb3_ext_hresp_o     (hresp_o),
    .ahb3_mem_hsel        (m_hsel),
    .ahb3_mem_haddr       (m_haddr),
    .ahb3_mem_hwdata      (m_hwdata),
    .ahb3_mem_hwrite      (m_hwrite),
    .ahb3_mem_hsize       (m_hsize),
    .ahb3_mem_hburst      (m_hburst),
    .ahb3_mem_hprot       (m_hprot),
    .ahb3_mem_htrans      (m_htrans),
    .ahb3_mem_hmastlock   (m_hmastlock),
    .ahb3_mem_hrdata      (m_hrdata),
    .ahb3_mem_hready      (m_hready),
    .ahb3_mem_hresp       (m_hresp)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ap(int n, logic [31:0] a, logic wr, logic [31:0] wd, logic lk);
    hsel[n]      = 1'b1;
    htrans[n]    = HTRANS_NONSEQ;
    haddr[n]     = a;
    hwrite[n]    = wr;
    hwdata[n]    = wd;
    hsize[n]     = 3'b010;
    hmastlock[n] = lk;
  endtask

  task automatic drop_ap(int n);
    hsel[n]      = 1'b0;
    htrans[n]    = HTRANS_IDLE;
    hmastlock[n] = 1'b0;
  endtask

  task automatic exp_slv(logic [31:0] a, logic wr, logic [31:0] wd);
    slv_q.push_back('{a, wr, wd});
  endtask

  task automatic exp_cmp(int n, int st, logic [31:0] rd, int nr);
    cmp_q.push_back('{n, st, rd, nr});
  endtask

  task automatic wait_done(string nm, int budget);
    int k;
    k = 0;
    while ((slv_q.size() != 0 || cmp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (slv_q.size() != 0 || cmp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout: outstanding slave=%0d tile=%0d required 0", nm, slv_q.size(), cmp_q.size());
      slv_q.delete();
      cmp_q.delete();
    end
  endtask

  // Memory slave model: wait states, two-cycle ERROR, hrdata valid only on the final data cycle.
  initial begin
    int   drem;
    logic derr;
    logic ap;
    logic rs;
    drem = 0;
    derr = 1'b0;
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      ap = m_hsel && (m_htrans == HTRANS_NONSEQ) && m_hready;
      rs = rst;
      @(posedge clk);
      #1;
      if (drem > 0) drem--;
      if (ap) begin
        derr = sl_err;
        drem = sl_err ? 2 : sl_wait + 1;
      end
      if (!rs || !rst) drem = 0;
      if (drem == 0) begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = 32'hBAD0_0000;
      end else begin
        m_hready = (drem == 1);
        m_hresp  = derr;
        m_hrdata = (drem == 1) ? sl_rdata : 32'hBAD0_0000;
      end
    end
  end

  // Monitor: slave-side requests and tile-side completions are popped against the queues.
  initial begin
    int   cnt[NODES];
    int   rc[NODES];
    logic d_act;
    slv_t cur;
    cmp_t e;
    d_act = 1'b0;
    cur   = '{32'h0, 1'b0, 32'h0};
    for (int i = 0; i < NODES; i++) begin
      cnt[i] = 0;
      rc[i]  = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        d_act = 1'b0;
        for (int i = 0; i < NODES; i++) begin
          cnt[i] = 0;
          rc[i]  = 0;
        end
      end else begin
        if (d_act && m_hready) begin
          if (cur.wr) chk("slv_hwdata", m_hwdata, cur.wdata);
          d_act = 1'b0;
        end
        if (m_hsel && (m_htrans == HTRANS_NONSEQ) && m_hready) begin
          if (slv_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slv_unexpected: actual addr=0x%0h required no transfer", m_haddr);
          end else begin
            cur = slv_q.pop_front();
            chk("slv_haddr", m_haddr, cur.addr);
            chk("slv_hwrite", m_hwrite, cur.wr);
            chk("slv_hburst", m_hburst, HBURST_SINGLE);
            d_act = 1'b1;
          end
        end
        for (int i = 0; i < NODES; i++) begin
          if (hresp_o[i]) rc[i]++;
          if (!hready_o[i]) begin
            cnt[i]++;
          end else if (cnt[i] > 0) begin
            if (cmp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL tile_unexpected: actual node=%0d stall=%0d required no completion", i, cnt[i]);
            end else begin
              e = cmp_q.pop_front();
              chk("tile_node", i, e.node);
              chk("tile_stall", cnt[i], e.stall);
              chk("tile_hrdata", hrdata_o[i], e.rdata);
              chk("tile_hresp_cycles", rc[i], e.nresp);
            end
            cnt[i] = 0;
            rc[i]  = 0;
          end else if (hresp_o[i]) begin
            total++;
            bad++;
            $display("FAIL idle_hresp: actual node=%0d hresp=1 required 0", i);
            rc[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual time limit reached required test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    hsel = '0; haddr = '0; hwdata = '0; hwrite = '0; hsize = '0;
    hburst = '0; hprot = '0; htrans = '0; hmastlock = '0;
    repeat (3) tick();
    chk("rst_hready", hready_o, 4'hF);
    chk("rst_hresp", hresp_o, 4'h0);
    for (int i = 0; i < NODES; i++) chk("rst_hrdata", hrdata_o[i], 32'h0);
    chk("rst_mem_hsel", m_hsel, 1'b0);
    chk("rst_mem_htrans", m_htrans, HTRANS_IDLE);
    chk("rst_pend", dut.r_pend, 4'h0);
    rst = 1'b1;
    tick();

    // All four nodes write together: granted 0,1,2,3, each stalled 4 cycles longer than the last.
    sl_rdata = 32'h0;
    for (int i = 0; i < NODES; i++) begin
      drive_ap(i, 32'h2000 + 32'(i) * 32'h100, 1'b1, 32'h10 * 32'(i), 1'b0);
      exp_slv(32'h2000 + 32'(i) * 32'h100, 1'b1, 32'h10 * 32'(i));
      exp_cmp(i, 2 + 4 * i, 32'h0, 0);
    end
    tick();
    for (int i = 0; i < NODES; i++) drop_ap(i);
    wait_done("all_write", 60);

    // Zero-wait read by node 2.
    sl_rdata = 32'hDEADBEEF;
    drive_ap(2, 32'h1000, 1'b0, 32'h0, 1'b0);
    exp_slv(32'h1000, 1'b0, 32'h0);
    exp_cmp(2, 2, 32'hDEADBEEF, 0);
    tick();
    drop_ap(2);
    wait_done("read_n2", 20);

    // Node 1 write with three slave wait states.
    sl_wait  = 3;
    sl_rdata = 32'h1111_0001;
    drive_ap(1, 32'h3000, 1'b1, 32'hA5A5_0001, 1'b0);
    exp_slv(32'h3000, 1'b1, 32'hA5A5_0001);
    exp_cmp(1, 5, 32'h1111_0001, 0);
    tick();
    drop_ap(1);
    wait_done("wait_n1", 30);
    sl_wait = 0;

    // Two-cycle ERROR for node 3, then the FSM must be back in IDLE.
    sl_err   = 1'b1;
    sl_rdata = 32'hE000_0003;
    drive_ap(3, 32'h4000, 1'b0, 32'h0, 1'b0);
    exp_slv(32'h4000, 1'b0, 32'h0);
    exp_cmp(3, 4, 32'hE000_0003, 2);
    tick();
    drop_ap(3);
    wait_done("err_n3", 30);
    sl_err = 1'b0;
    chk("err_fsm_idle", dut.r_state, IDLE);

    // Node 0 locked pair against pending node 1.
    sl_rdata = 32'h5555_0000;
`ifdef MPSOC_AHB3_EXT_ARB_LOCK_EN
    exp_slv(32'h5000, 1'b0, 32'h0);
    exp_slv(32'h5004, 1'b0, 32'h0);
    exp_slv(32'h6000, 1'b0, 32'h0);
    exp_cmp(0, 2, 32'h5555_0000, 0);
    exp_cmp(0, 3, 32'h5555_0000, 0);
    exp_cmp(1, 10, 32'h5555_0000, 0);
`else
    exp_slv(32'h5000, 1'b0, 32'h0);
    exp_slv(32'h6000, 1'b0, 32'h0);
    exp_slv(32'h5004, 1'b0, 32'h0);
    exp_cmp(0, 2, 32'h5555_0000, 0);
    exp_cmp(1, 6, 32'h5555_0000, 0);
    exp_cmp(0, 7, 32'h5555_0000, 0);
`endif
    drive_ap(0, 32'h5000, 1'b0, 32'h0, 1'b1);
    drive_ap(1, 32'h6000, 1'b0, 32'h0, 1'b0);
    tick();
    drop_ap(0);
    drop_ap(1);
    k = 0;
    while (hready_o[0] == 1'b0 && k < 20) begin
      tick();
      k++;
    end
    drive_ap(0, 32'h5004, 1'b0, 32'h0, 1'b1);
    tick();
    drop_ap(0);
    wait_done("lock_seq", 60);

    // Reset in the middle of a waited data phase drops the transfer.
    sl_wait = 3;
    drive_ap(2, 32'h7000, 1'b1, 32'h77, 1'b0);
    exp_slv(32'h7000, 1'b1, 32'h77);
    tick();
    drop_ap(2);
    tick();
    chk("pre_rst_state", dut.r_state, DATA);
    rst = 1'b0;
    tick();
    chk("midrst_hready", hready_o, 4'hF);
    chk("midrst_hresp", hresp_o, 4'h0);
    chk("midrst_mem_htrans", m_htrans, HTRANS_IDLE);
    chk("midrst_pend", dut.r_pend, 4'h0);
    chk("midrst_state", dut.r_state, IDLE);
    for (int i = 0; i < NODES; i++) chk("midrst_hrdata", hrdata_o[i], 32'h0);
    rst = 1'b1;
    sl_wait = 0;
    tick();

    // Normal service resumes after reset.
    sl_rdata = 32'h8888_0001;
    drive_ap(1, 32'h8000, 1'b0, 32'h0, 1'b0);
    exp_slv(32'h8000, 1'b0, 32'h0);
    exp_cmp(1, 2, 32'h8888_0001, 0);
    tick();
    drop_ap(1);
    wait_done("post_rst", 20);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpsoc_ahb3_ext_arbiter.md
# mpsoc_ahb3_ext_arbiter

Shared external-memory arbiter that sits directly downstream of the 2D MPSoC's per-tile AHB3-Lite external ports. It consumes all `NODES` master-side `ahb3_ext_*` buses and serialises them onto one AHB3-Lite slave port, the shared off-chip memory controller. Each transfer is captured in a per-node pending register and granted round-robin. The requesting tile is stalled with `hready` low until its slave transfer completes.

## Interface
Parameters:
- `PLEN`, 32, address width
- `XLEN`, 32, data width
- `NODES`, 4, number of tile master ports (X*Y)

Ports:
- `clk`  in  1  single clock for all logic
- `rst`  in  1  asynchronous, active-low reset
- `ahb3_ext_hsel_i`  in  [NODES-1:0]  tile select
- `ahb3_ext_haddr_i`  in  [NODES-1:0][PLEN-1:0]  tile address
- `ahb3_ext_hwdata_i`  in  [NODES-1:0][XLEN-1:0]  tile write data
- `ahb3_ext_hwrite_i`  in  [NODES-1:0]  tile write flag
- `ahb3_ext_hsize_i` / `ahb3_ext_hburst_i`  in  [NODES-1:0][2:0]  tile size / burst
- `ahb3_ext_hprot_i`  in  [NODES-1:0][3:0]  tile protection
- `ahb3_ext_htrans_i`  in  [NODES-1:0][1:0]  tile transfer type
- `ahb3_ext_hmastlock_i`  in  [NODES-1:0]  tile lock
- `ahb3_ext_hrdata_o`  out  [NODES-1:0][XLEN-1:0]  read data to tile
- `ahb3_ext_hready_o` / `ahb3_ext_hresp_o`  out  [NODES-1:0]  ready / response to tile
- `ahb3_mem_hsel`, `ahb3_mem_haddr`, `ahb3_mem_hwdata`, `ahb3_mem_hwrite`, `ahb3_mem_hsize`, `ahb3_mem_hburst`, `ahb3_mem_hprot`, `ahb3_mem_htrans`, `ahb3_mem_hmastlock`  out  single-port widths as above  slave request
- `ahb3_mem_hrdata`  in  [XLEN-1:0]; `ahb3_mem_hready`, `ahb3_mem_hresp`  in  1  slave response

## Operation
- **Capture:** node i captures its address phase when `hsel_i[i] & htrans_i[i][1] & hready_o[i]`.
  - Captured fields are haddr, hwrite, hsize, hprot and hmastlock.
  - Capture sets `pend[i]`.
  - SEQ is treated as NONSEQ.
- **Stall:** `hready_o[i]=0` while `pend[i]`, except during node i's RESP cycle. The tile therefore holds hwdata stable through its extended data phase.
- **Grant:** round-robin among `pend` in IDLE. Search starts at `last+1` modulo NODES. `last` updates on every grant.
- **FSM states:** IDLE, ADDR, DATA, ERR, RESP.
  - IDLE→ADDR when any pend.
  - ADDR: drive `ahb3_mem_hsel=1`, `htrans=NONSEQ`, `hburst=SINGLE`, and the captured fields. Move to DATA when `ahb3_mem_hready=1`.
  - DATA: `htrans=IDLE`, `hwdata=ahb3_ext_hwdata_i[owner]`. When `ahb3_mem_hready=1`, register hrdata/hresp. Go to RESP if hresp=0, or ERR if hresp=1.
  - ERR: owner sees `hresp=1`, `hready=0`. Next state RESP.
  - RESP: owner sees `hready=1` and the registered hrdata/hresp. Clear `pend[owner]`. Next state IDLE.
- **Simultaneous events:** a new capture by the owner in its RESP cycle wins over the clear, so `pend` stays 1.
- **Outputs to idle nodes:** `hready_o=1`, `hresp_o=0`, hrdata holds its last value.
- **Reset mid-operation:** everything returns to reset values and in-flight transfers are dropped.
- **Reset values:**
  - tile side: `hready_o=1`, `hresp_o=0`, `hrdata_o=0`
  - slave side: all outputs 0 (`htrans=IDLE`)
  - internal: pend=0, state=IDLE, `last=NODES-1` so node 0 wins first.

## Timing
- Tile address phase in cycle T → `pend` set at T+1, tile `hready_o` low at T+1.
- Slave address phase at T+1 (ADDR), slave data phase at T+2.
- With a zero-wait slave, the tile sees `hready_o=1` at T+3. Minimum stall is 2 cycles; each slave wait state adds 1.
- Error response adds 1 cycle (ERR).
- Back-to-back grants are separated by one IDLE cycle, so per-transfer throughput is 4 cycles.
- Worst-case wait for a node = (NODES-1) × service time, so there is no starvation.

## Configuration
- `MPSOC_AHB3_EXT_ARB_LOCK_EN` defined:
  - A granted transfer with hmastlock=1 sets `lock_q`.
  - While `lock_q` is set, IDLE grants only the owner.
  - `lock_q` clears on the owner's next captured transfer with hmastlock=0, or when the owner drives `htrans=IDLE` while its `hready_o=1`.
  - `ahb3_mem_hmastlock` is forwarded.
- Undefined: hmastlock is ignored, `ahb3_mem_hmastlock=0`, and arbitration is pure round-robin.

## Structure
- Package `mpsoc_ahb3_pkg` holds:
  - HTRANS constants (IDLE/BUSY/NONSEQ/SEQ)
  - HBURST_SINGLE
  - the `arb_state_t` enum (IDLE, ADDR, DATA, ERR, RESP)
- Sub-module `mpsoc_rr_arbiter` (NODES request bits, registered last-grant pointer, one-hot grant plus index).
- Pending registers and FSM live in the top module.

## Test plan
- Node 2 reads 0x1000, slave returns 0xDEADBEEF with zero wait → `hready_o[2]` low for 2 cycles, then high with `hrdata_o[2]=0xDEADBEEF`, `hresp_o[2]=0`.
- Nodes 0–3 all write in the same cycle → slave sees order 0,1,2,3, each write carrying its own hwdata (0x10·i).
- Node 1 write, slave inserts 3 wait states → `hready_o[1]` low for 5 cycles, other nodes' `hready_o` stay 1.
- Slave returns 2-cycle ERROR for node 3 → `hresp_o[3]=1` for 2 cycles, `hready_o[3]` 0 then 1, FSM back to IDLE.
- LOCK_EN: node 0 issues 2 locked transfers while node 1 is pending → slave sees 0,0,1. Without the macro → 0,1,0.
- `rst` asserted low during DATA → next edge: all `hready_o=1`, `ahb3_mem_htrans=IDLE`, pend=0.
